// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the registered 1-to-N stream demultiplexer.
package stream_demux_pkg;

    // Packet lock state: IDLE routes by in_sel, LOCKED routes by the latched select.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    // Bit offset of channel 'chan' inside the flattened output payload bus.
    function automatic int slice_lo(input int chan, input int width);
        return chan * width;
    endfunction

endpackage

// File: rtl/stream_demux_slice.sv
// One-entry valid/ready holding register carrying {dest, last, data}.
// Push side: o_ready = !vld || i_dest_ready; a push on the same edge as a pop
// reloads the entry with no bubble.
module stream_demux_slice
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [SEL_W-1:0]  i_dest,
    input  logic              i_last,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_dest_ready,
    output logic              o_vld,
    output logic [SEL_W-1:0]  o_dest,
    output logic              o_last,
    output logic [DATA_W-1:0] o_data
);

    logic              r_vld;
    logic [SEL_W-1:0]  r_dest;
    logic              r_last;
    logic [DATA_W-1:0] r_data;
    logic              w_push;

    assign o_ready = !r_vld || i_dest_ready;
    assign w_push  = i_valid && o_ready;

    // Load on push, otherwise empty the entry when the destination takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_dest <= '0;
            r_last <= 1'b0;
            r_data <= '0;
        end else if (w_push) begin
            r_vld  <= 1'b1;
            r_dest <= i_dest;
            r_last <= i_last;
            r_data <= i_data;
        end else if (r_vld && i_dest_ready) begin
            r_vld  <= 1'b0;
        end
    end

    assign o_vld  = r_vld;
    assign o_dest = r_dest;
    assign o_last = r_last;
    assign o_data = r_data;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with optional per-packet route lock
// and a saturating counter of beats dropped for an out-of-range select.
// Handshake (all ports): a beat moves on a rising edge where valid && ready;
// valid never depends on ready, and payload is held stable while valid && !ready.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int N_OUT    = 4,
    parameter int SEL_W    = $clog2(N_OUT),
    parameter int PKT_MODE = 1,
    parameter int ERR_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_last,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_last,
    output logic [ERR_W-1:0]        drop_cnt,
    output logic                    o_dbg_state
);

    lock_state_t       r_state;
    lock_state_t       w_state_nxt;
    logic [SEL_W-1:0]  r_lock_sel;
    logic [SEL_W-1:0]  w_lock_sel_nxt;
    logic [ERR_W-1:0]  r_drop_cnt;

    logic [SEL_W-1:0]  w_eff_sel;
    logic              w_sel_ok;
    logic              w_accept;
    logic              w_drop;
    logic              w_slice_ready;
    logic              w_dest_ready;
    logic              w_vld_q;
    logic [SEL_W-1:0]  w_dest_q;
    logic              w_last_q;
    logic [DATA_W-1:0] w_data_q;

    // Select resolution: a locked packet ignores in_sel.
    assign w_eff_sel = (r_state == ST_LOCKED) ? r_lock_sel : in_sel;
    assign w_sel_ok  = (32'(w_eff_sel) < N_OUT);

    // Invalid-select beats are always accepted so the producer never stalls on them.
    assign in_ready  = w_sel_ok ? w_slice_ready : 1'b1;
    assign w_accept  = in_valid && in_ready;
    assign w_drop    = in_valid && !w_sel_ok;

    stream_demux_slice #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_slice (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (in_valid && w_sel_ok),
        .o_ready      (w_slice_ready),
        .i_dest       (w_eff_sel),
        .i_last       (in_last),
        .i_data       (in_data),
        .i_dest_ready (w_dest_ready),
        .o_vld        (w_vld_q),
        .o_dest       (w_dest_q),
        .o_last       (w_last_q),
        .o_data       (w_data_q)
    );

    // Lock FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_lock_sel <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_sel <= w_lock_sel_nxt;
        end
    end

    // Lock FSM next state: lock on a non-last first beat, unlock on the last beat.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_sel_nxt = r_lock_sel;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !in_last && (PKT_MODE != 0)) begin
                    w_state_nxt    = ST_LOCKED;
                    w_lock_sel_nxt = in_sel;
                end
            end
            ST_LOCKED: begin
                if (w_accept && in_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output fan-out: only the held destination sees valid, data and last.
    always_comb begin
        out_valid    = '0;
        out_last     = '0;
        out_data     = '0;
        w_dest_ready = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (w_vld_q && (w_dest_q == SEL_W'(k))) begin
                out_valid[k]                            = 1'b1;
                out_last[k]                             = w_last_q;
                out_data[slice_lo(k, DATA_W) +: DATA_W] = w_data_q;
                w_dest_ready                            = out_ready[k];
            end
        end
    end

    // Saturating count of beats discarded for an out-of-range select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {ERR_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_cnt    = r_drop_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_stream_demux.sv
// Directed scoreboard bench for stream_demux: packet-mode and beat-mode
// instances on a 4-channel bus, plus two 5-channel instances for drop counting.
module tb_stream_demux;
    import stream_demux_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // ---------------- group A: N_OUT=4, PKT_MODE=1 and PKT_MODE=0 ----------------
    logic        a_in_valid = 1'b0;
    logic [7:0]  a_in_data = '0;
    logic [1:0]  a_in_sel = '0;
    logic        a_in_last = 1'b0;
    logic [3:0]  a_out_ready = 4'hF;
    logic        a_in_ready, p0_in_ready;
    logic [3:0]  a_out_valid, a_out_last, p0_out_valid, p0_out_last;
    logic [31:0] a_out_data, p0_out_data;
    logic [7:0]  a_drop, p0_drop;
    logic        a_state, p0_state;

    stream_demux #(.DATA_W(8), .N_OUT(4), .PKT_MODE(1), .ERR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_sel(a_in_sel), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .drop_cnt(a_drop), .o_dbg_state(a_state));

    stream_demux #(.DATA_W(8), .N_OUT(4), .PKT_MODE(0), .ERR_W(8)) u_dut_p0 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(p0_in_ready),
        .in_data(a_in_data), .in_sel(a_in_sel), .in_last(a_in_last),
        .out_valid(p0_out_valid), .out_ready(a_out_ready), .out_data(p0_out_data),
        .out_last(p0_out_last), .drop_cnt(p0_drop), .o_dbg_state(p0_state));

    // ---------------- group B: N_OUT=5, ERR_W=8 and ERR_W=2 ----------------
    logic        b_in_valid = 1'b0;
    logic [7:0]  b_in_data = '0;
    logic [2:0]  b_in_sel = '0;
    logic        b_in_last = 1'b0;
    logic [4:0]  b_out_ready = 5'h1F;
    logic        b_in_ready, s_in_ready;
    logic [4:0]  b_out_valid, b_out_last, s_out_valid, s_out_last;
    logic [39:0] b_out_data, s_out_data;
    logic [7:0]  b_drop;
    logic [1:0]  s_drop;
    logic        b_state, s_state;

    stream_demux #(.DATA_W(8), .N_OUT(5), .PKT_MODE(1), .ERR_W(8)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_sel(b_in_sel), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .drop_cnt(b_drop), .o_dbg_state(b_state));

    stream_demux #(.DATA_W(8), .N_OUT(5), .PKT_MODE(1), .ERR_W(2)) u_dut5s (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(s_in_ready),
        .in_data(b_in_data), .in_sel(b_in_sel), .in_last(b_in_last),
        .out_valid(s_out_valid), .out_ready(b_out_ready), .out_data(s_out_data),
        .out_last(s_out_last), .drop_cnt(s_drop), .o_dbg_state(s_state));

    // ---------------- scoreboard ----------------
    // Entry packing: {channel[3:0], last, data[7:0]}.
    logic [12:0] exp_q[$];
    logic [12:0] exp_p0[$];
    logic [12:0] exp_q5[$];
    int          p0_stamp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=0x%0h expected=none (t=%0t)", name, act, $time);
    endtask

    // 1 when at most one channel is valid and idle channels carry zero data/last.
    function automatic logic shape_ok4(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l);
        logic ok = ($countones(v) <= 1);
        for (int k = 0; k < 4; k++)
            if (!v[k] && ((d[k*8 +: 8] != 8'h00) || l[k])) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic shape_ok5(input logic [4:0] v, input logic [39:0] d, input logic [4:0] l);
        logic ok = ($countones(v) <= 1);
        for (int k = 0; k < 5; k++)
            if (!v[k] && ((d[k*8 +: 8] != 8'h00) || l[k])) ok = 1'b0;
        return ok;
    endfunction

    // Monitor: every output transfer pops and compares against its expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            check("a_shape", shape_ok4(a_out_valid, a_out_data, a_out_last), 1);
            check("p0_shape", shape_ok4(p0_out_valid, p0_out_data, p0_out_last), 1);
            check("b_shape", shape_ok5(b_out_valid, b_out_data, b_out_last), 1);
            for (int k = 0; k < 4; k++) begin
                if (a_out_valid[k] && a_out_ready[k]) begin
                    if (exp_q.size() == 0) fail_now("a_unexpected_beat", {k[3:0], a_out_last[k], a_out_data[k*8 +: 8]});
                    else check("a_beat", {k[3:0], a_out_last[k], a_out_data[k*8 +: 8]}, exp_q.pop_front());
                end
                if (p0_out_valid[k] && a_out_ready[k]) begin
                    p0_stamp_q.push_back(cyc);
                    if (exp_p0.size() == 0) fail_now("p0_unexpected_beat", {k[3:0], p0_out_last[k], p0_out_data[k*8 +: 8]});
                    else check("p0_beat", {k[3:0], p0_out_last[k], p0_out_data[k*8 +: 8]}, exp_p0.pop_front());
                end
            end
            for (int k = 0; k < 5; k++) begin
                if (b_out_valid[k] && b_out_ready[k]) begin
                    if (exp_q5.size() == 0) fail_now("b_unexpected_beat", {k[3:0], b_out_last[k], b_out_data[k*8 +: 8]});
                    else check("b_beat", {k[3:0], b_out_last[k], b_out_data[k*8 +: 8]}, exp_q5.pop_front());
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_a(input logic [7:0] d, input logic [1:0] s, input logic l,
                          input int ch_main, input int ch_p0);
        int n = 0;
        a_in_valid = 1'b1; a_in_data = d; a_in_sel = s; a_in_last = l;
        #1;
        while (!(a_in_ready && p0_in_ready) && (n < 50)) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) begin
            fail_now("a_accept_timeout", {56'h0, d});
        end else begin
            exp_q.push_back({4'(ch_main), l, d});
            exp_p0.push_back({4'(ch_p0), l, d});
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    // Beats on group B never wait: ready is required the moment valid rises.
    task automatic send_b(input logic [7:0] d, input logic [2:0] s, input logic l, input logic emit);
        b_in_valid = 1'b1; b_in_data = d; b_in_sel = s; b_in_last = l;
        #1;
        check("b_in_ready", {b_in_ready, s_in_ready}, 2'b11);
        if (emit) exp_q5.push_back({4'(s), l, d});
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Global bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed test sequence ----------------
    initial begin
        // Reset state, held low for a few cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {a_in_ready, p0_in_ready, b_in_ready, s_in_ready}, 4'hF);
        check("rst_out_last", a_out_last, 0);
        check("rst_drop_cnt", {a_drop, b_drop, 6'h0, s_drop}, 0);
        check("rst_state", a_state, ST_IDLE);
        idle(1);

        // Single beats, all ready.
        check("t1_ready0", a_in_ready, 1);
        send_a(8'h11, 2'd0, 1'b1, 0, 0);
        check("t1_lat_ch0", {a_out_valid, a_out_data}, {4'b0001, 32'h0000_0011});
        check("t1_ready1", a_in_ready, 1);
        send_a(8'h22, 2'd2, 1'b1, 2, 2);
        check("t1_lat_ch2", {a_out_valid, a_out_data}, {4'b0100, 32'h0022_0000});
        check("t1_ready2", a_in_ready, 1);
        send_a(8'h33, 2'd3, 1'b1, 3, 3);
        check("t1_lat_ch3", {a_out_valid, a_out_data}, {4'b1000, 32'h3300_0000});
        idle(2);

        // 3-beat packet locks to channel 1 in packet mode; beat mode follows in_sel.
        send_a(8'hA0, 2'd1, 1'b0, 1, 1);
        check("t2_locked", a_state, ST_LOCKED);
        check("t2_p0_idle", p0_state, ST_IDLE);
        send_a(8'hA1, 2'd3, 1'b0, 1, 3);
        send_a(8'hA2, 2'd0, 1'b1, 1, 0);
        check("t2_unlocked", a_state, ST_IDLE);
        send_a(8'hA8, 2'd2, 1'b1, 2, 2);
        idle(2);

        // Stall on channel 2 with a second beat waiting.
        a_out_ready = 4'b1011;
        send_a(8'h55, 2'd2, 1'b1, 2, 2);
        a_in_valid = 1'b1; a_in_data = 8'h66; a_in_sel = 2'd0; a_in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_stall_ready", {a_in_ready, p0_in_ready}, 2'b00);
            check("t3_stall_data", {a_out_valid, a_out_data[23:16]}, {4'b0100, 8'h55});
            @(posedge clk); #1;
        end
        a_out_ready = 4'hF;
        exp_q.push_back({4'd0, 1'b1, 8'h66});
        exp_p0.push_back({4'd0, 1'b1, 8'h66});
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        check("t3_next_beat", {a_out_valid, a_out_data[7:0]}, {4'b0001, 8'h66});
        idle(3);

        // Back-to-back beats: one per cycle, no bubbles.
        p0_stamp_q.delete();
        send_a(8'h70, 2'd0, 1'b1, 0, 0);
        send_a(8'h71, 2'd1, 1'b1, 1, 1);
        send_a(8'h72, 2'd2, 1'b1, 2, 2);
        send_a(8'h73, 2'd3, 1'b1, 3, 3);
        idle(3);
        check("t4_beats", p0_stamp_q.size(), 4);
        if (p0_stamp_q.size() == 4)
            for (int i = 0; i < 3; i++)
                check("t4_no_bubble", p0_stamp_q[i+1] - p0_stamp_q[i], 1);

        // Invalid select on N_OUT=5: dropped, counted, saturating at ERR_W=2.
        for (int i = 0; i < 4; i++) send_b(8'h60 + 8'(i), 3'd6, 1'b1, 1'b0);
        check("t5_drop4", b_drop, 4);
        check("t5_sat4", s_drop, 3);
        send_b(8'h64, 3'd6, 1'b1, 1'b0);
        check("t5_drop5", b_drop, 5);
        check("t5_sat5", s_drop, 3);
        send_b(8'h44, 3'd4, 1'b1, 1'b1);
        check("t5_ch4_nodrop", b_drop, 5);
        // Locked invalid packet: every beat dropped despite valid in_sel.
        send_b(8'h80, 3'd7, 1'b0, 1'b0);
        send_b(8'h81, 3'd4, 1'b0, 1'b0);
        send_b(8'h82, 3'd4, 1'b1, 1'b0);
        check("t5_pkt_drop", b_drop, 8);
        check("t5_pkt_state", {b_state, s_state}, 2'b00);
        idle(2);

        // Reset while locked with a held beat.
        send_a(8'hB0, 2'd1, 1'b0, 1, 1);
        a_out_ready = 4'b1101;
        idle(1);
        check("t6_pre_locked", {a_state, a_out_valid}, {ST_LOCKED, 4'b0010});
        rst_n = 1'b0;
        exp_q.delete();
        exp_p0.delete();
        #1;
        check("t6_rst_async", {a_out_valid, a_out_data, a_out_last}, 0);
        check("t6_rst_state", a_state, ST_IDLE);
        idle(2);
        rst_n = 1'b1;
        a_out_ready = 4'hF;
        #1;
        check("t6_post_ready", a_in_ready, 1);
        send_a(8'hC3, 2'd3, 1'b1, 3, 3);
        check("t6_route_ch3", {a_out_valid, a_out_data[31:24]}, {4'b1000, 8'hC3});
        idle(3);

        // Leftovers and untouched counters.
        check("end_exp_q", exp_q.size(), 0);
        check("end_exp_p0", exp_p0.size(), 0);
        check("end_exp_q5", exp_q5.size(), 0);
        check("end_no_drops_a", {a_drop, p0_drop, p0_state}, 0);
        check("end_s_quiet", {s_out_valid, s_out_data, s_out_last}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parametrised, registered 1-to-N stream demultiplexer: the sequential successor of the combinational 1x4 demux.
- Routes each beat of a valid/ready input stream to one of N_OUT output channels, chosen by a select field.
- Optional packet mode holds the route from the first beat of a packet through its last beat.
- Sits between a single producer and N consumer FIFOs/engines.

Parameters:
- DATA_W, 8, payload width in bits.
- N_OUT, 4, number of output channels; legal range 2..16.
- SEL_W, $clog2(N_OUT), select width; derived, do not override.
- PKT_MODE, 1, 1 = select locked per packet using in_last; 0 = select sampled on every beat.
- ERR_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_W  input payload.
- in_sel  in  SEL_W  destination channel index.
- in_last  in  1  last beat of packet; ignored when PKT_MODE=0.
- out_valid  out  N_OUT  per-channel valid, one-hot or zero.
- out_ready  in  N_OUT  per-channel ready.
- out_data  out  N_OUT*DATA_W  flattened payload; channel k occupies bits [k*DATA_W +: DATA_W].
- out_last  out  N_OUT  per-channel last.
- drop_cnt  out  ERR_W  count of beats discarded for an invalid select.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n). Asserting rst_n low immediately clears all state.
- Reset values: out_valid=0, out_data=0, out_last=0, drop_cnt=0, lock FSM=IDLE, holding register empty. in_ready=1 once reset is released.
- Handshake: a beat transfers on any edge where valid && ready. Valid must not depend on ready. Data is held stable while valid && !ready.
- Holding register: one entry containing data_q, dest_q, last_q and vld_q.
- in_ready = !vld_q || out_ready[dest_q]. This gives full throughput, one beat per cycle, while the destination is ready.
- Latency: a beat accepted at edge t appears on its channel after edge t (1 cycle).
- Outputs: out_valid[k] = vld_q && (dest_q==k). Channel dest_q carries data_q and last_q. All other channels drive zero data and last=0.
- Head-of-line blocking is intended: a stalled destination stalls all channels.
- Lock FSM, states IDLE and LOCKED:
  - IDLE, beat accepted with in_last=0 and PKT_MODE=1: latch lock_sel=in_sel and go to LOCKED.
  - IDLE, beat accepted with in_last=1: stay IDLE; a single-beat packet.
  - LOCKED: the beat is routed to lock_sel and in_sel is ignored. An accepted beat with in_last=1 returns the FSM to IDLE.
  - PKT_MODE=0: the FSM stays in IDLE permanently and in_sel is used on every beat.
- Effective select = LOCKED ? lock_sel : in_sel.
- Invalid select (effective select >= N_OUT, possible only when N_OUT is not a power of 2):
  - The beat is accepted (in_ready=1 that cycle, independent of the holding register) and discarded.
  - The holding register is not written.
  - drop_cnt increments and saturates at all-ones.
  - In packet mode the whole locked packet is dropped beat by beat.
- Simultaneous pop and push: the holding register drains and reloads on the same edge, with no bubble.
- Reset mid-packet: the lock and any held beat are discarded. No partial-packet recovery.
- out_ready asserted on a channel with out_valid=0 has no effect.

Decomposition:
- Package stream_demux_pkg: lock state enum (IDLE, LOCKED) and a function computing the flattened data slice offset.
- One natural sub-module: stream_demux_slice, a one-entry valid/ready register holding {dest, last, data}.
- The top level keeps the lock FSM, select resolution, output fan-out and drop counter.

Test Plan:
- Reset, then single beats data=0x11 sel=0, 0x22 sel=2, 0x33 sel=3, all out_ready=1 -> each appears 1 cycle later on the matching channel only; other channels show data 0; in_ready stays 1.
- PKT_MODE=1, 3-beat packet 0xA0,0xA1,0xA2 with sel=1,3,0 and last on the third beat -> all three beats appear on channel 1; the next packet with sel=2 goes to channel 2.
- Channel 2 out_ready=0 for 5 cycles with a beat held for channel 2 -> in_ready=0 and out_data stable for those 5 cycles; on release the beat transfers, followed by the queued beat on the next cycle.
- N_OUT=5 (SEL_W=3), sel=6 on 4 single beats -> nothing is emitted, drop_cnt=4; with ERR_W=2 and 5 drops, drop_cnt saturates at 3.
- PKT_MODE=0 back-to-back beats with sel 0,1,2,3 and all outputs ready -> one beat per cycle, each on its own channel, with no bubbles.
- Assert rst_n low while LOCKED with a held beat, release after 2 cycles -> all outputs 0 and FSM IDLE; the next beat with sel=3 routes to channel 3 even though the earlier lock was channel 1.
